uart_output: RTL and testbench
==============================

# uart_output

Formats a 16-bit calculator result as decimal ASCII and sends it one byte at a time to the UART transmitter. It does the reverse of the input parser, which turns keystrokes into operands. It sits between the ALU result and the UART TX byte interface. The message is an optional '-', then the digits with leading zeros suppressed, then a line terminator.

## Interface
- SIGNED, default 1: 1 means `result` is two's complement and a '-' is sent when it is negative; 0 means `result` is unsigned.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- result  input  16  value to print; sampled only on an accepted start.
- start  input  1  request to print; a level that is acted on only while idle.
- tx_ready  input  1  high when the UART TX can accept a byte.
- tx_data  output  8  ASCII byte to send; valid while tx_send is high.
- tx_send  output  1  one-cycle strobe that hands tx_data to the TX.
- busy  output  1  high from the cycle after an accepted start until done pulses.
- done  output  1  one-cycle pulse after the last byte is handed off.

## Operation
- Reset values: tx_data=8'h00, tx_send=0, busy=0, done=0; state=IDLE; internal magnitude and digit registers are cleared.
- IDLE: when start=1, latch the magnitude and the sign flag, then go to SIGN.
  - Negative means SIGNED=1 and result[15]=1.
  - Magnitude is -result (16-bit unsigned) when negative, otherwise result. 0x8000 gives 32768 with no overflow.
- SIGN: if negative, send '-' (8'h2D). Either way, continue to DIGIT with position p=0.
- DIGIT: repeated subtraction against pow[p] = 10000, 1000, 100, 10, 1.
  - While mag ≥ pow[p]: mag -= pow[p] and digit++, one subtraction per cycle.
  - When mag < pow[p], the digit is final.
  - Send 8'h30+digit if digit≠0, or a nonzero digit was already sent, or p=4. Otherwise skip it.
  - Then clear digit and increment p. After p=4, go to TERM.
- TERM: send CR (8'h0D); with TX_CRLF_EN also send LF (8'h0A). Then go to FIN.
- FIN: pulse done for one cycle and return to IDLE. busy drops in the same cycle.
- Send sub-sequence (used by every "send" above):
  - Wait while tx_ready=0.
  - When tx_ready=1, drive tx_data and assert tx_send for exactly one cycle.
  - Hold one guard cycle with tx_send=0 and tx_ready ignored. The TX must deassert tx_ready within that guard cycle.
  - Then continue.
- start while busy: ignored; it is not queued.
- Changes to result after latching do not affect the message in progress.
- Emitted message lengths:
  - Minimum: 2 bytes ("0",CR), or 3 bytes with LF.
  - Maximum: 7 bytes ("-32768",CR), or 8 bytes with LF.

## Timing
- Start acceptance: start is sampled on edge N; busy=1 from N+1.
- Byte to strobe: a byte's tx_send rises no earlier than 1 cycle after its source state is entered, given tx_ready=1.
- Digit cost: each digit takes digit+1 compute cycles, so at most 10 per position.
- Strobe spacing: consecutive tx_send pulses are at least 2 cycles apart, plus any stall on tx_ready.
- tx_ready stall: tx_ready=0 stalls the FSM indefinitely. No byte is dropped or duplicated.
- done timing: done pulses 1 cycle after the final guard cycle. A start held high through FIN is accepted on the cycle after done.
- Reset mid-operation:
  - Takes effect at the next edge and wins over every other input.
  - The message is abandoned and tx_send is low from that edge on.
  - done does not pulse.

## Configuration
- TX_CRLF_EN defined: the terminator is CR then LF (8'h0D, 8'h0A).
- TX_CRLF_EN undefined: the terminator is CR only. The LF state and its logic are compiled out.

## Test plan
- result=16'd123, tx_ready=1, TX_CRLF_EN defined → strobes '1','2','3',8'h0D,8'h0A, then one done pulse; nothing before '1'.
- result=0 → '0',CR(,LF); result=16'd1000 → '1','0','0','0',CR (interior zeros are sent).
- SIGNED=1: result=16'hFFFB → '-','5',CR; result=16'h8000 → '-','3','2','7','6','8',CR. SIGNED=0: result=16'hFFFF → '6','5','5','3','5',CR.
- Stall: hold tx_ready=0 for 20 cycles before the second byte of 123 → tx_send stays 0 throughout; '2' is sent once after release; byte count is unchanged.
- Change result to 999 and pulse start during transmission of 123 → the output is still "123"; the 999 request is not queued.
- Assert reset during the '2' digit of 123 → tx_send=0 and busy=0 after the edge, done never pulses; a new start with 7 → '7',CR.

Source files
------------

// File: rtl/uart_output.sv
// Prints a 16-bit result as decimal ASCII ('-', digits without leading zeros, CR[,LF])
// through a ready/strobe byte interface. Define TX_CRLF_EN to append LF after CR.
module uart_output #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        start,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SIGN   = 4'd1;
    localparam logic [3:0] S_DIGIT  = 4'd2;
    localparam logic [3:0] S_TERM   = 4'd3;
`ifdef TX_CRLF_EN
    localparam logic [3:0] S_LF     = 4'd4;
`endif
    localparam logic [3:0] S_FIN    = 4'd5;
    localparam logic [3:0] S_SEND   = 4'd6;
    localparam logic [3:0] S_STROBE = 4'd7;
    localparam logic [3:0] S_GUARD  = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [3:0]  ret_q, ret_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] mag_q, mag_d;
    logic [3:0]  digit_q, digit_d;
    logic [2:0]  pos_q, pos_d;
    logic        neg_q, neg_d;
    logic        seen_q, seen_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_send_q, tx_send_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] pow;
    logic [3:0]  after_digit;
    logic        neg_in;

    assign neg_in = SIGNED && result[15];

    always_comb begin
        case (pos_q)
            3'd0:    pow = 16'd10000;
            3'd1:    pow = 16'd1000;
            3'd2:    pow = 16'd100;
            3'd3:    pow = 16'd10;
            default: pow = 16'd1;
        endcase
        after_digit = (pos_q == 3'd4) ? S_TERM : S_DIGIT;
    end

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        byte_d    = byte_q;
        mag_d     = mag_q;
        digit_d   = digit_q;
        pos_d     = pos_q;
        neg_d     = neg_q;
        seen_d    = seen_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d   = neg_in;
                    mag_d   = neg_in ? (~result + 16'd1) : result;
                    digit_d = '0;
                    pos_d   = '0;
                    seen_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                pos_d = '0;
                if (neg_q) begin
                    byte_d  = 8'h2D;
                    ret_d   = S_DIGIT;
                    state_d = S_SEND;
                end else begin
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                // one subtraction per cycle; the cycle with mag < pow settles the digit
                if (mag_q >= pow) begin
                    mag_d   = mag_q - pow;
                    digit_d = digit_q + 4'd1;
                end else begin
                    digit_d = '0;
                    pos_d   = pos_q + 3'd1;
                    if (digit_q != 4'd0 || seen_q || pos_q == 3'd4) begin
                        seen_d  = 1'b1;
                        byte_d  = 8'h30 + {4'h0, digit_q};
                        ret_d   = after_digit;
                        state_d = S_SEND;
                    end else begin
                        state_d = after_digit;
                    end
                end
            end
            S_TERM: begin
                byte_d  = 8'h0D;
`ifdef TX_CRLF_EN
                ret_d   = S_LF;
`else
                ret_d   = S_FIN;
`endif
                state_d = S_SEND;
            end
`ifdef TX_CRLF_EN
            S_LF: begin
                byte_d  = 8'h0A;
                ret_d   = S_FIN;
                state_d = S_SEND;
            end
`endif
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_SEND: begin
                if (tx_ready) begin
                    tx_data_d = byte_q;
                    tx_send_d = 1'b1;
                    state_d   = S_STROBE;
                end
            end
            // strobe cycle and guard cycle both ignore tx_ready
            S_STROBE: state_d = S_GUARD;
            S_GUARD:  state_d = ret_q;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            byte_q    <= '0;
            mag_q     <= '0;
            digit_q   <= '0;
            pos_q     <= '0;
            neg_q     <= 1'b0;
            seen_q    <= 1'b0;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            byte_q    <= byte_d;
            mag_q     <= mag_d;
            digit_q   <= digit_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            seen_q    <= seen_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_send = tx_send_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_uart_output.sv
// Scoreboard bench for uart_output: a signed and an unsigned instance share stimulus;
// expected byte streams come from an integer-to-decimal model.
module tb_uart_output;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] result = '0;
    logic        start = 1'b0;
    logic        rdy_mode = 1'b0;
    logic        rdy_hold = 1'b1;
    logic        rdy_rnd = 1'b1;
    logic        tx_ready;

    logic [7:0]  tx_data0, tx_data1;
    logic        tx_send0, tx_send1, busy0, busy1, done0, done1;

    int errors = 0;
    int checks = 0;
    int dcnt0 = 0;
    int dcnt1 = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #5 clk = ~clk;

    assign tx_ready = rdy_mode ? rdy_rnd : rdy_hold;
    always @(negedge clk) rdy_rnd <= ($urandom_range(0, 3) != 0);

    uart_output #(.SIGNED(1'b1)) dut0 (
        .clk(clk), .reset(reset), .result(result), .start(start), .tx_ready(tx_ready),
        .tx_data(tx_data0), .tx_send(tx_send0), .busy(busy0), .done(done0)
    );
    uart_output #(.SIGNED(1'b0)) dut1 (
        .clk(clk), .reset(reset), .result(result), .start(start), .tx_ready(tx_ready),
        .tx_data(tx_data1), .tx_send(tx_send1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: print the integer value of r in decimal, then CR[,LF], then a done marker.
    task automatic push_expected(input int k, input logic [15:0] r, input bit sgn);
        int v, m;
        int digs[$];
        logic [8:0] seq[$];
        v = (sgn && r[15]) ? int'(r) - 65536 : int'(r);
        m = (v < 0) ? -v : v;
        do begin
            digs.push_front(m % 10);
            m = m / 10;
        end while (m > 0);
        if (v < 0) seq.push_back(9'h02D);
        foreach (digs[i]) seq.push_back(9'(48 + digs[i]));
        seq.push_back(9'h00D);
`ifdef TX_CRLF_EN
        seq.push_back(9'h00A);
`endif
        seq.push_back(9'h100);
        foreach (seq[i]) begin
            if (k == 0) q0.push_back(seq[i]);
            else q1.push_back(seq[i]);
        end
    endtask

    task automatic pop_cmp(input int k, input logic [8:0] got);
        logic [8:0] exp;
        checks++;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("FAIL out%0d: unexpected output %h with nothing expected", k, got);
        end else begin
            exp = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL out%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (tx_send0) pop_cmp(0, {1'b0, tx_data0});
        if (done0) begin pop_cmp(0, 9'h100); dcnt0++; end
        if (tx_send1) pop_cmp(1, {1'b0, tx_data1});
        if (done1) begin pop_cmp(1, 9'h100); dcnt1++; end
    end

    task automatic start_msg(input logic [15:0] r);
        push_expected(0, r, 1'b1);
        push_expected(1, r, 1'b0);
        @(negedge clk);
        result = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy0_after_start", {15'd0, busy0}, 16'd1);
        chk("busy1_after_start", {15'd0, busy1}, 16'd1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int t1);
        int n = 0;
        while ((dcnt0 < t0 || dcnt1 < t1) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL done_timeout: done counts %0d/%0d required %0d/%0d", dcnt0, dcnt1, t0, t1);
        end
        @(negedge clk);
    endtask

    task automatic run_msg(input logic [15:0] r);
        int t0, t1;
        t0 = dcnt0 + 1;
        t1 = dcnt1 + 1;
        start_msg(r);
        wait_done(t0, t1);
    endtask

    task automatic wait_first_send();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_send0 && n < 200);
        checks++;
        if (!tx_send0) begin
            errors++;
            $display("FAIL first_send_timeout: tx_send0 got 0 expected 1");
        end
    endtask

    logic [15:0] corners [9] = '{16'd123, 16'd0, 16'd1000, 16'hFFFB, 16'h8000,
                                 16'hFFFF, 16'h7FFF, 16'd1, 16'd10};

    initial begin
        int t0, t1;
        repeat (3) @(negedge clk);
        chk("rst_tx_data0", {8'd0, tx_data0}, 16'd0);
        chk("rst_tx_send0", {15'd0, tx_send0}, 16'd0);
        chk("rst_busy0", {15'd0, busy0}, 16'd0);
        chk("rst_done0", {15'd0, done0}, 16'd0);
        chk("rst_tx_send1", {15'd0, tx_send1}, 16'd0);
        chk("rst_busy1", {15'd0, busy1}, 16'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (corners[i]) run_msg(corners[i]);

        // stall before the second byte of 123
        t0 = dcnt0 + 1;
        t1 = dcnt1 + 1;
        start_msg(16'd123);
        wait_first_send();
        rdy_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_tx_send0", {15'd0, tx_send0}, 16'd0);
            chk("stall_tx_send1", {15'd0, tx_send1}, 16'd0);
        end
        rdy_hold = 1'b1;
        wait_done(t0, t1);

        // a new start while busy is neither used nor queued
        t0 = dcnt0 + 1;
        t1 = dcnt1 + 1;
        start_msg(16'd123);
        repeat (4) @(negedge clk);
        result = 16'd999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, t1);
        repeat (20) @(negedge clk);
        chk("no_queued_busy0", {15'd0, busy0}, 16'd0);

        // reset while the '2' digit is being computed
        t0 = dcnt0;
        start_msg(16'd123);
        wait_first_send();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx_send0", {15'd0, tx_send0}, 16'd0);
        chk("midrst_busy0", {15'd0, busy0}, 16'd0);
        chk("midrst_tx_send1", {15'd0, tx_send1}, 16'd0);
        chk("midrst_busy1", {15'd0, busy1}, 16'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            chk("midrst_no_done0", {15'd0, done0}, 16'd0);
        end
        chk("midrst_done_count", 16'(dcnt0), 16'(t0));
        run_msg(16'd7);

        rdy_mode = 1'b1;
        for (int i = 0; i < 30; i++) run_msg(16'($urandom));
        foreach (corners[i]) run_msg(corners[i]);
        rdy_mode = 1'b0;

        repeat (10) @(negedge clk);
        chk("q0_drained", 16'(q0.size()), 16'd0);
        chk("q1_drained", 16'(q1.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
